pc_sequencer: RTL and testbench

Control-side companion of the program counter: drives CountEn, Load and the 8-bit load target into the PC and consumes the PC's Y output as the fetch address. It fetches one instruction word per PC value with a ready handshake to program memory, and forwards ordinary instructions downstream with valid/stall flow control. It resolves JMP, JZ and HALT locally, so the PC is advanced or loaded exactly once per instruction.

---
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer that drives an external 8-bit program counter.
// Optional fetch watchdog is enabled by defining PC_SEQ_WATCHDOG_EN.
module pc_sequencer #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              Clk,
   input  logic              nReset,
   input  logic              Run,
   input  logic [ADDR_W-1:0] PcIn,
   output logic              MemReq,
   input  logic              MemReady,
   input  logic [DATA_W-1:0] MemData,
   input  logic              Zero,
   input  logic              Stall,
   output logic [DATA_W-1:0] Instr,
   output logic              InstrValid,
   output logic              CountEn,
   output logic              Load,
   output logic [ADDR_W-1:0] Target,
   output logic              Halted,
   output logic              FetchErr
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StExec,
      StStep,
      StJump,
      StHalt
   } state_e;

   localparam logic [3:0] OpJmp  = 4'hF;
   localparam logic [3:0] OpJz   = 4'hE;
   localparam logic [3:0] OpHalt = 4'hC;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] target_q, target_d;
   logic [3:0]        opcode;
   logic              is_plain;
   logic              timeout;

   assign opcode   = instr_q[DATA_W-1 -: 4];
   assign is_plain = (opcode != OpJmp) && (opcode != OpJz) && (opcode != OpHalt);

   // PcIn is the memory address seen by program memory; the sequencer never reads it.
   logic unused_pc;
   assign unused_pc = ^PcIn;

`ifdef PC_SEQ_WATCHDOG_EN
   logic [7:0] wait_q, wait_d;
   logic       fetch_err_q, fetch_err_d;

   assign timeout = (state_q == StFetch) && !MemReady && (wait_q == 8'(TIMEOUT - 1));

   always_comb begin
      wait_d      = 8'd0;
      fetch_err_d = fetch_err_q;
      if (state_q == StFetch && !MemReady) begin
         wait_d = wait_q + 8'd1;
      end
      if (timeout) begin
         fetch_err_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         wait_q      <= 8'd0;
         fetch_err_q <= 1'b0;
      end else begin
         wait_q      <= wait_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   assign FetchErr = fetch_err_q;
`else
   assign timeout  = 1'b0;
   assign FetchErr = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      target_d = target_q;
      unique case (state_q)
         StIdle: begin
            if (Run) state_d = StFetch;
         end
         StFetch: begin
            if (MemReady) begin
               instr_d = MemData;
               state_d = StExec;
            end else if (timeout) begin
               state_d = StHalt;
            end
         end
         StExec: begin
            case (opcode)
               OpJmp: begin
                  target_d = instr_q[ADDR_W-1:0];
                  state_d  = StJump;
               end
               OpJz: begin
                  if (Zero) begin
                     target_d = instr_q[ADDR_W-1:0];
                     state_d  = StJump;
                  end else begin
                     state_d = StStep;
                  end
               end
               OpHalt:  state_d = StHalt;
               default: if (!Stall) state_d = StStep;
            endcase
         end
         StStep, StJump: begin
            state_d = Run ? StFetch : StIdle;
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q  <= StIdle;
         instr_q  <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         target_q <= target_d;
      end
   end

   // Pulses are pure state decodes, so an async reset kills them immediately.
   assign MemReq     = (state_q == StFetch);
   assign InstrValid = (state_q == StExec) && is_plain;
   assign CountEn    = (state_q == StStep);
   assign Load       = (state_q == StJump);
   assign Halted     = (state_q == StHalt);
   assign Instr      = instr_q;
   assign Target     = target_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC and program memory;
// instruction and jump-target scoreboards are checked by a cycle monitor.
module tb_pc_sequencer;

   logic        Clk;
   logic        nReset;
   logic        Run;
   logic [7:0]  PcIn;
   logic        MemReq;
   logic        MemReady;
   logic [15:0] MemData;
   logic        Zero;
   logic        Stall;
   logic [15:0] Instr;
   logic        InstrValid;
   logic        CountEn;
   logic        Load;
   logic [7:0]  Target;
   logic        Halted;
   logic        FetchErr;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [256];
   logic [7:0]  pc;
   logic        pc_set;
   logic [7:0]  pc_val;
   logic        iv_prev;

   logic [15:0] exp_q[$];
   logic [7:0]  tgt_q[$];

   pc_sequencer #(
      .DATA_W (16),
      .ADDR_W (8),
      .TIMEOUT(15)
   ) dut (
      .Clk       (Clk),
      .nReset    (nReset),
      .Run       (Run),
      .PcIn      (PcIn),
      .MemReq    (MemReq),
      .MemReady  (MemReady),
      .MemData   (MemData),
      .Zero      (Zero),
      .Stall     (Stall),
      .Instr     (Instr),
      .InstrValid(InstrValid),
      .CountEn   (CountEn),
      .Load      (Load),
      .Target    (Target),
      .Halted    (Halted),
      .FetchErr  (FetchErr)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Program counter model: increments on CountEn, loads Target on Load.
   always @(posedge Clk) begin
      if (pc_set) pc <= pc_val;
      else if (CountEn) pc <= pc + 8'd1;
      else if (Load) pc <= Target;
   end

   assign PcIn    = pc;
   assign MemData = mem[PcIn];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compares {MemReq, InstrValid, CountEn, Load, Halted}.
   task automatic outs(input string tag, input logic [4:0] exp);
      chk(tag, {27'd0, MemReq, InstrValid, CountEn, Load, Halted}, {27'd0, exp});
   endtask

   task automatic nxt();
      @(negedge Clk);
   endtask

   always @(negedge Clk) begin
      if (nReset === 1'b1) begin
         chk("excl_pulse", {31'd0, CountEn & Load}, 32'd0);
         if (InstrValid && !iv_prev) begin
            if (exp_q.size() == 0) chk("instr_sb_empty", 32'd1, 32'd0);
            else chk("instr_sb", {16'd0, Instr}, {16'd0, exp_q.pop_front()});
         end
         if (Load) begin
            if (tgt_q.size() == 0) chk("target_sb_empty", 32'd1, 32'd0);
            else chk("target_sb", {24'd0, Target}, {24'd0, tgt_q.pop_front()});
         end
      end
      iv_prev = InstrValid;
   end

   initial begin
      iv_prev  = 1'b0;
      nReset   = 1'b0;
      Run      = 1'b0;
      Stall    = 1'b0;
      Zero     = 1'b0;
      MemReady = 1'b1;
      pc_set   = 1'b1;
      pc_val   = 8'd1;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h01] = 16'h1234;
      mem[8'h02] = 16'hF0FA;
      mem[8'hFA] = 16'hE010;
      mem[8'hFB] = 16'hE010;
      mem[8'h10] = 16'h1111;
      mem[8'h11] = 16'hF0FF;
      mem[8'hFF] = 16'h2222;
      mem[8'h00] = 16'h3333;
      mem[8'h20] = 16'hC000;

      nxt();
      outs("reset_outs", 5'b00000);
      chk("reset_instr", {16'd0, Instr}, 32'd0);
      chk("reset_target", {24'd0, Target}, 32'd0);
      chk("reset_fetcherr", {31'd0, FetchErr}, 32'd0);
      pc_set = 1'b0;
      nReset = 1'b1;
      nxt();
      outs("idle_no_run", 5'b00000);

      // Sequential instruction, zero-wait memory.
      Run = 1'b1;
      exp_q.push_back(16'h1234);
      nxt();
      outs("fetch1", 5'b10000);
      chk("fetch1_pc", {24'd0, PcIn}, 32'd1);
      nxt();
      outs("exec1", 5'b01000);
      nxt();
      outs("step1", 5'b00100);
      nxt();
      outs("fetch2", 5'b10000);
      chk("fetch2_pc", {24'd0, PcIn}, 32'd2);

      // JMP 250.
      tgt_q.push_back(8'd250);
      nxt();
      outs("exec_jmp", 5'b00000);
      nxt();
      outs("jump_jmp", 5'b00010);
      nxt();
      outs("fetch_fa", 5'b10000);
      chk("fetch_fa_pc", {24'd0, PcIn}, 32'd250);

      // JZ not taken, then JZ taken.
      nxt();
      outs("exec_jz0", 5'b00000);
      nxt();
      outs("step_jz0", 5'b00100);
      nxt();
      chk("fetch_fb_pc", {24'd0, PcIn}, 32'd251);
      Zero = 1'b1;
      tgt_q.push_back(8'h10);
      nxt();
      outs("exec_jz1", 5'b00000);
      nxt();
      outs("jump_jz1", 5'b00010);
      Zero = 1'b0;
      nxt();
      chk("fetch_10_pc", {24'd0, PcIn}, 32'h10);

      // Downstream stall for four EXEC cycles.
      exp_q.push_back(16'h1111);
      Stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nxt();
         outs("exec_stall", 5'b01000);
         chk("exec_stall_instr", {16'd0, Instr}, 32'h1111);
         if (i == 3) Stall = 1'b0;
      end
      nxt();
      outs("step_after_stall", 5'b00100);

      // Memory wait: three extra FETCH cycles.
      nxt();
      chk("fetch_11_pc", {24'd0, PcIn}, 32'h11);
      MemReady = 1'b0;
      tgt_q.push_back(8'hFF);
      for (int i = 0; i < 3; i++) begin
         nxt();
         outs("fetch_wait", 5'b10000);
         if (i == 2) MemReady = 1'b1;
      end
      nxt();
      outs("exec_jmp_ff", 5'b00000);
      nxt();
      outs("jump_ff", 5'b00010);

      // Wrap-around at PC 0xFF.
      exp_q.push_back(16'h2222);
      nxt();
      chk("fetch_ff_pc", {24'd0, PcIn}, 32'hFF);
      nxt();
      outs("exec_ff", 5'b01000);
      nxt();
      outs("step_ff", 5'b00100);
      nxt();
      outs("fetch_00", 5'b10000);
      chk("fetch_00_pc", {24'd0, PcIn}, 32'h00);

      // Run drops during EXEC: finish the step, then park.
      exp_q.push_back(16'h3333);
      nxt();
      outs("exec_00", 5'b01000);
      Run = 1'b0;
      nxt();
      outs("step_00", 5'b00100);
      nxt();
      outs("park_idle", 5'b00000);
      chk("park_pc", {24'd0, PcIn}, 32'd1);
      nxt();
      outs("park_idle2", 5'b00000);

      // Reset asserted in the middle of STEP.
      Run = 1'b1;
      exp_q.push_back(16'h1234);
      nxt();
      outs("refetch", 5'b10000);
      nxt();
      outs("reexec", 5'b01000);
      nxt();
      outs("restep", 5'b00100);
      #2 nReset = 1'b0;
      #1;
      outs("async_reset_outs", 5'b00000);
      chk("async_reset_instr", {16'd0, Instr}, 32'd0);
      chk("async_reset_pc", {24'd0, PcIn}, 32'd1);
      pc_set = 1'b1;
      pc_val = 8'h20;
      nxt();
      outs("held_reset", 5'b00000);
      pc_set = 1'b0;
      nReset = 1'b1;

      // HALT is terminal even with Run high.
      nxt();
      chk("fetch_20_pc", {24'd0, PcIn}, 32'h20);
      nxt();
      outs("exec_halt", 5'b00000);
      for (int i = 0; i < 4; i++) begin
         nxt();
         outs("halted", 5'b00001);
      end
      chk("instr_sb_drained", exp_q.size(), 32'd0);
      chk("target_sb_drained", tgt_q.size(), 32'd0);

`ifdef PC_SEQ_WATCHDOG_EN
      nReset   = 1'b0;
      Run      = 1'b0;
      MemReady = 1'b0;
      nxt();
      nReset = 1'b1;
      Run    = 1'b1;
      for (int i = 0; i < 15; i++) begin
         nxt();
         outs("wd_fetch", 5'b10000);
         chk("wd_no_err", {31'd0, FetchErr}, 32'd0);
      end
      nxt();
      outs("wd_halt", 5'b00001);
      chk("wd_fetcherr", {31'd0, FetchErr}, 32'd1);
      nxt();
      chk("wd_sticky", {31'd0, FetchErr}, 32'd1);
`else
      chk("fetcherr_tied", {31'd0, FetchErr}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
